systolic_operand_feeder: RTL and testbench
==========================================

// Module: systolic_operand_feeder
// PURPOSE
//  Transmit side of the PE operand interface: buffers an NxK A matrix and a KxN B matrix,
//  then drives skewed 8-bit A streams into the N array rows and B streams into the N array
//  columns so operand pairs meet in each processing element. Sits between the host load
//  port and the west/north edges of the NxN PE array. Zero-pads outside the valid skew window.
// PARAMETERS
//  N   2                    array dimension (rows = cols of PE grid)
//  K   N                    inner dimension; beats of real data per row/column
//  AW  $clog2(N*K) (min 1)  load address width
// PORTS
//  clk        in   1      clock; single clock domain
//  rst        in   1      reset; asynchronous, active-low
//  ld_valid   in   1      load beat valid
//  ld_ready   out  1      load accepted when ld_valid & ld_ready
//  ld_sel     in   1      0 = A buffer, 1 = B buffer
//  ld_addr    in   AW     A: i*K+k (row i, col k); B: k*N+j (row k, col j)
//  ld_data    in   8      operand byte
//  start      in   1      begin streaming (sampled only in IDLE)
//  a_out      out  8*N    row i operand on bits [8i+7:8i]
//  b_out      out  8*N    col j operand on bits [8j+7:8j]
//  feed_valid out  1      a_out/b_out carry a stream beat
//  busy       out  1      high in STREAM
//  done       out  1      one-cycle pulse after last beat
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low.
//  Reset: state=IDLE, a_out=0, b_out=0, feed_valid=0, busy=0, done=0, ld_ready=1,
//   beat counter t=0, both buffers cleared to 0.
//  FSM: IDLE -> STREAM on start; STREAM -> DONE when t==K+N-2 beat issued; DONE -> IDLE.
//  ld_ready = (state==IDLE). Loads in STREAM/DONE ignored (no write). ld_addr >= N*K ignored.
//  Load and start in the same IDLE cycle: write commits, stream uses updated buffer.
//  start outside IDLE ignored (no restart, no queueing).
//  Stream: all outputs registered; start sampled at edge 0 -> beat t=0 visible after edge 1.
//   Beats t = 0..K+N-2 (K+N-1 cycles), feed_valid=1 for each.
//   a_out row i = A[i][t-i] if 0 <= t-i < K else 8'h00.
//   b_out col j = B[t-j][j] if 0 <= t-j < K else 8'h00.
//  done=1 for exactly the cycle after the last beat (state DONE); feed_valid=0, a_out=b_out=0.
//  Outside STREAM a_out=b_out=0, feed_valid=0.
//  Buffers retained across streams; restreaming without reload repeats identical data.
//  Counter t sized $clog2(K+N) bits; no wrap within a stream; cleared on entry to STREAM.
//  Reset asserted mid-stream: outputs zero immediately (async), FSM IDLE, buffers cleared,
//   no done pulse.
// TESTING
//  N=2,K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> 3 beats: a_out row0 1,2,0;
//   row1 0,3,4; b_out col0 5,7,0; col1 0,6,8; done 1 cycle after beat 3.
//  Same load, start twice back-to-back (second during STREAM) -> one stream only, one done.
//  ld_valid during STREAM with ld_sel=0,addr=0,data=9 -> ld_ready=0, restream shows row0 1,2,0.
//  rst low at beat 1 -> a_out/b_out/feed_valid 0 same cycle, no done; restream gives all zeros.
//  N=4,K=3, A[i][k]=10i+k, B[k][j]=10k+j -> 6 beats; row3 zeros at t=0..2, then 30,31,32.
//  ld_addr=N*K out of range -> no buffer changes; subsequent stream matches prior contents.

Source files
------------

// File: rtl/systolic_operand_feeder.sv
// Operand feeder for an NxN systolic array: buffers A (NxK) and B (KxN) from a load port,
// then streams skewed, zero-padded rows of A west-side and columns of B north-side.
module systolic_operand_feeder #(
  parameter int unsigned N  = 2,
  parameter int unsigned K  = N,
  parameter int unsigned AW = (N * K > 1) ? $clog2(N * K) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            ld_sel,
  input  logic [AW-1:0]   ld_addr,
  input  logic [7:0]      ld_data,
  input  logic            start,
  output logic [8*N-1:0]  a_out,
  output logic [8*N-1:0]  b_out,
  output logic            feed_valid,
  output logic            busy,
  output logic            done
);

  localparam int unsigned Depth = N * K;
  localparam int unsigned TW    = (K + N > 1) ? $clog2(K + N) : 1;
  localparam logic [TW-1:0] LastBeat = TW'(K + N - 2);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [7:0]     a_mem_q [Depth];
  logic [7:0]     a_mem_d [Depth];
  logic [7:0]     b_mem_q [Depth];
  logic [7:0]     b_mem_d [Depth];
  logic [8*N-1:0] a_out_q, a_out_d;
  logic [8*N-1:0] b_out_q, b_out_d;
  logic           fv_q, fv_d;
  logic           done_q, done_d;
  logic           ld_we;
  int             tap;

  assign ld_we = (state_q == StIdle) && ld_valid && (32'(ld_addr) < 32'(Depth));

  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    if (ld_we) begin
      if (ld_sel) b_mem_d[ld_addr] = ld_data;
      else        a_mem_d[ld_addr] = ld_data;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStream;
          t_d     = '0;
        end
      end
      StStream: begin
        if (t_q == LastBeat) begin
          state_d = StDone;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Row i lags row 0 by i beats (same for columns), so element k of row i appears at t = i + k.
  always_comb begin
    a_out_d = '0;
    b_out_d = '0;
    tap     = 0;
    fv_d    = (state_q == StStream);
    done_d  = (state_q == StDone);
    if (state_q == StStream) begin
      for (int i = 0; i < int'(N); i++) begin
        tap = int'(t_q) - i;
        if (tap >= 0 && tap < int'(K)) begin
          a_out_d[8*i +: 8] = a_mem_q[AW'(i * int'(K) + tap)];
          b_out_d[8*i +: 8] = b_mem_q[AW'(tap * int'(N) + i)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      a_mem_q <= '{default: '0};
      b_mem_q <= '{default: '0};
      a_out_q <= '0;
      b_out_q <= '0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
    end
  end

  assign ld_ready   = (state_q == StIdle);
  assign busy       = (state_q == StStream);
  assign a_out      = a_out_q;
  assign b_out      = b_out_q;
  assign feed_valid = fv_q;
  assign done       = done_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder: a 2x2 instance for the stream/control corners
// and a 4x3 instance for wider skew and out-of-range loads.
module tb_systolic_operand_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        d2_ld_valid, d2_ld_ready, d2_ld_sel, d2_start;
  logic [1:0]  d2_ld_addr;
  logic [7:0]  d2_ld_data;
  logic [15:0] d2_a, d2_b;
  logic        d2_fv, d2_busy, d2_done;

  logic        d4_ld_valid, d4_ld_ready, d4_ld_sel, d4_start;
  logic [3:0]  d4_ld_addr;
  logic [7:0]  d4_ld_data;
  logic [31:0] d4_a, d4_b;
  logic        d4_fv, d4_busy, d4_done;

  systolic_operand_feeder #(.N(2), .K(2)) u_dut2 (
    .clk(clk), .rst(rst), .ld_valid(d2_ld_valid), .ld_ready(d2_ld_ready), .ld_sel(d2_ld_sel),
    .ld_addr(d2_ld_addr), .ld_data(d2_ld_data), .start(d2_start), .a_out(d2_a), .b_out(d2_b),
    .feed_valid(d2_fv), .busy(d2_busy), .done(d2_done)
  );

  systolic_operand_feeder #(.N(4), .K(3)) u_dut4 (
    .clk(clk), .rst(rst), .ld_valid(d4_ld_valid), .ld_ready(d4_ld_ready), .ld_sel(d4_ld_sel),
    .ld_addr(d4_ld_addr), .ld_data(d4_ld_data), .start(d4_start), .a_out(d4_a), .b_out(d4_b),
    .feed_valid(d4_fv), .busy(d4_busy), .done(d4_done)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        fv;
    logic        done;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] row3_tab[6];
  int n_vec = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load2(input logic sel, input logic [1:0] addr, input logic [7:0] data);
    d2_ld_valid = 1'b1;
    d2_ld_sel   = sel;
    d2_ld_addr  = addr;
    d2_ld_data  = data;
    tick();
    d2_ld_valid = 1'b0;
  endtask

  task automatic load4(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    d4_ld_valid = 1'b1;
    d4_ld_sel   = sel;
    d4_ld_addr  = addr;
    d4_ld_data  = data;
    tick();
    d4_ld_valid = 1'b0;
  endtask

  // Start a 2x2 stream and compare the 3 beats, the done cycle and the idle cycle after it.
  task automatic play2(input string tag, input bit zeros);
    d2_start = 1'b1;
    tick();
    d2_start = 1'b0;
    chk($sformatf("%s busy", tag), 32'(d2_busy), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("%s c%0d a", tag, c), 32'(d2_a), zeros ? 32'd0 : 32'(vecs[c].a));
      chk($sformatf("%s c%0d b", tag, c), 32'(d2_b), zeros ? 32'd0 : 32'(vecs[c].b));
      chk($sformatf("%s c%0d fv", tag, c), 32'(d2_fv), 32'(vecs[c].fv));
      chk($sformatf("%s c%0d done", tag, c), 32'(d2_done), 32'(vecs[c].done));
    end
  endtask

  function automatic logic [31:0] model_a4(input int t);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < 3) r[8*i +: 8] = 8'(10 * i + (t - i));
    return r;
  endfunction

  function automatic logic [31:0] model_b4(input int t);
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++)
      if (t - j >= 0 && t - j < 3) r[8*j +: 8] = 8'(10 * (t - j) + j);
    return r;
  endfunction

  task automatic play4(input string tag);
    d4_start = 1'b1;
    tick();
    d4_start = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("%s t%0d a", tag, t), d4_a, model_a4(t));
      chk($sformatf("%s t%0d b", tag, t), d4_b, model_b4(t));
      chk($sformatf("%s t%0d row3", tag, t), 32'(d4_a[31:24]), 32'(row3_tab[t]));
      chk($sformatf("%s t%0d fv", tag, t), 32'(d4_fv), 32'd1);
    end
    tick();
    chk($sformatf("%s done", tag), 32'(d4_done), 32'd1);
    chk($sformatf("%s done fv", tag), 32'(d4_fv), 32'd0);
    chk($sformatf("%s done a", tag), d4_a, 32'd0);
    tick();
    chk($sformatf("%s done drop", tag), 32'(d4_done), 32'd0);
  endtask

  initial begin
    int n_fv;
    int n_done;

    vecs[0] = '{16'h0001, 16'h0005, 1'b1, 1'b0};
    vecs[1] = '{16'h0302, 16'h0607, 1'b1, 1'b0};
    vecs[2] = '{16'h0400, 16'h0800, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
    row3_tab = '{8'd0, 8'd0, 8'd0, 8'd30, 8'd31, 8'd32};

    rst = 1'b0;
    d2_ld_valid = 1'b0; d2_ld_sel = 1'b0; d2_ld_addr = '0; d2_ld_data = '0; d2_start = 1'b0;
    d4_ld_valid = 1'b0; d4_ld_sel = 1'b0; d4_ld_addr = '0; d4_ld_data = '0; d4_start = 1'b0;
    #12;
    chk("reset a", 32'(d2_a), 32'd0);
    chk("reset fv", 32'(d2_fv), 32'd0);
    chk("reset busy", 32'(d2_busy), 32'd0);
    chk("reset done", 32'(d2_done), 32'd0);
    chk("reset ld_ready", 32'(d2_ld_ready), 32'd1);
    rst = 1'b1;
    tick();

    // Basic 2x2 stream
    load2(1'b0, 2'd0, 8'd1); load2(1'b0, 2'd1, 8'd2);
    load2(1'b0, 2'd2, 8'd3); load2(1'b0, 2'd3, 8'd4);
    load2(1'b1, 2'd0, 8'd5); load2(1'b1, 2'd1, 8'd6);
    load2(1'b1, 2'd2, 8'd7); load2(1'b1, 2'd3, 8'd8);
    play2("basic", 1'b0);

    // Second start arriving during STREAM must not retrigger
    d2_start = 1'b1;
    tick();
    tick();
    d2_start = 1'b0;
    n_fv   = int'(d2_fv);
    n_done = int'(d2_done);
    for (int c = 0; c < 8; c++) begin
      tick();
      n_fv   += int'(d2_fv);
      n_done += int'(d2_done);
    end
    chk("dblstart beats", 32'(n_fv), 32'd3);
    chk("dblstart dones", 32'(n_done), 32'd1);

    // Load attempted mid-stream is refused and leaves the buffer intact
    d2_start = 1'b1;
    tick();
    d2_start = 1'b0;
    d2_ld_valid = 1'b1; d2_ld_sel = 1'b0; d2_ld_addr = 2'd0; d2_ld_data = 8'd9;
    tick();
    chk("midload ld_ready", 32'(d2_ld_ready), 32'd0);
    tick();
    tick();
    d2_ld_valid = 1'b0;
    tick();
    play2("restream", 1'b0);

    // Asynchronous reset at beat 1
    d2_start = 1'b1;
    tick();
    d2_start = 1'b0;
    tick();
    tick();
    chk("prerst fv", 32'(d2_fv), 32'd1);
    chk("prerst a", 32'(d2_a), 32'h0302);
    #1 rst = 1'b0;
    #1;
    chk("rst a", 32'(d2_a), 32'd0);
    chk("rst b", 32'(d2_b), 32'd0);
    chk("rst fv", 32'(d2_fv), 32'd0);
    chk("rst busy", 32'(d2_busy), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    n_done = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_done += int'(d2_done);
    end
    chk("rst no done", 32'(n_done), 32'd0);
    play2("postrst", 1'b1);

    // 4x3 instance
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) load4(1'b0, 4'(i * 3 + k), 8'(10 * i + k));
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) load4(1'b1, 4'(k * 4 + j), 8'(10 * k + j));
    play4("n4k3");

    // Out-of-range addresses must not alter either buffer
    load4(1'b0, 4'd12, 8'hFF); load4(1'b0, 4'd13, 8'hFF); load4(1'b0, 4'd15, 8'hFF);
    load4(1'b1, 4'd12, 8'hFF); load4(1'b1, 4'd13, 8'hFF); load4(1'b1, 4'd15, 8'hFF);
    play4("oob");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
